pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, stall (hazard hold) and flush (bubble injection). It replaces the hand-written inter-stage registers (IF/ID, ID/EX, ...) of the 5-stage RISC-V core. An optional 2-entry skid buffer registers the upstream ready, so back-pressure does not form a combinational path across stages. Flush overwrites only a masked field with a bubble value, for example instruction := NOP while npc is kept.

---
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// This is a generic inter-stage pipeline register (IF/ID, ID/EX, ...). It has a
// valid/ready handshake, a stall that freezes the stage, and a flush that
// rewrites a masked field of the held payload with a bubble value.
//
// With SKID=1 a second entry (S) sits behind the main register (M). In this
// mode in_ready comes straight from a flop, so downstream back-pressure never
// forms a combinational path into the upstream stage. With SKID=0 the stage is
// a single register whose in_ready is combinational.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   stall      hazard hold: every register keeps its value, in_ready forced 0
//   flush      drop queued beats and turn M into a bubble (masked overwrite)
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts
//   out_data   payload held in the main register M
//   count      occupancy (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 64,
    parameter logic [DATA_W-1:0] RST_VAL     = {32'h8000_0000, 32'h0},
    parameter logic [DATA_W-1:0] BUBBLE_VAL  = 64'h0000_0000_0000_0013,
    parameter logic [DATA_W-1:0] FLUSH_MASK  = 64'h0000_0000_FFFF_FFFF,
    parameter bit                FLUSH_VALID = 1'b1,
    parameter bit                SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    // The state encoding equals the occupancy, so count is the state itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              ready_q, ready_d;

    logic              acc;
    logic              deq;
    logic [DATA_W-1:0] flush_data;

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = (state_q != StEmpty);
    assign out_data  = m_data_q;
    assign count     = state_q;

    // In skid mode ready comes from a flop, which breaks the back-pressure
    // path. Only stall reaches in_ready combinationally.
    assign in_ready = SKID ? (ready_q & ~stall)
                           : ((~out_valid | out_ready) & ~stall);

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready & ~stall;

    // Only the masked field takes the bubble; the rest (e.g. npc) survives.
    assign flush_data = (m_data_q & ~FLUSH_MASK) | (BUBBLE_VAL & FLUSH_MASK);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        ready_d  = ready_q;

        if (!stall) begin
            if (flush) begin
                // Leaving StTwo empties S; its stale data is never observed.
                // A beat accepted in this cycle is dropped.
                m_data_d = flush_data;
                state_d  = FLUSH_VALID ? StOne : StEmpty;
                ready_d  = 1'b1;
            end else if (SKID) begin
                unique case (state_q)
                    StEmpty: begin
                        if (acc) begin
                            m_data_d = in_data;
                            state_d  = StOne;
                        end
                    end
                    StOne: begin
                        if (acc && deq) begin
                            m_data_d = in_data;
                        end else if (acc) begin
                            s_data_d = in_data;
                            state_d  = StTwo;
                        end else if (deq) begin
                            state_d = StEmpty;
                        end
                    end
                    StTwo: begin
                        // ready_q is 0 here, so no beat can be accepted.
                        if (deq) begin
                            m_data_d = s_data_q;
                            state_d  = StOne;
                        end
                    end
                    default: begin
                        state_d = StEmpty;
                    end
                endcase
                ready_d = (state_d != StTwo);
            end else begin
                if (acc) begin
                    m_data_d = in_data;
                    state_d  = StOne;
                end else if (deq) begin
                    state_d = StEmpty;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            m_data_q <= RST_VAL;
            s_data_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives one SKID=1 instance (k=0) and one SKID=0 instance (k=1) with the
// same stimulus. Each instance has a behavioural model: a bounded list of
// queued beats plus the last value shown on out_data. Beats the model
// accepts are pushed into a per-instance expected queue. A monitor on the
// falling edge pops that queue whenever a DUT hands a beat downstream.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef logic [63:0] beat_t;

    localparam beat_t RSTV = 64'h8000_0000_0000_0000;
    localparam beat_t BUB  = 64'h0000_0000_0000_0013;
    localparam beat_t MASK = 64'h0000_0000_FFFF_FFFF;
    localparam bit    FV   = 1'b1;

    logic  clk = 1'b0;
    logic  rst;
    logic  stall, flush, in_valid, out_ready;
    beat_t in_data;

    logic       a_in_ready, a_out_valid;
    beat_t      a_out_data;
    logic [1:0] a_count;
    logic       b_in_ready, b_out_valid;
    beat_t      b_out_data;
    logic [1:0] b_count;

    pipe_stage_reg #(.SKID(1'b1)) u_a (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .count     (a_count)
    );

    pipe_stage_reg #(.SKID(1'b0)) u_b (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t exp_q0[$];
    beat_t exp_q1[$];

    // Model state per instance: queued beats, their number, ready for the
    // skid variant, and the value out_data should currently show.
    beat_t mbuf [2][2];
    int    mcnt [2];
    logic  mrdy [2];
    beat_t held [2];

    logic  m_acc, m_deq;
    beat_t m_bub;

    task automatic chk(input string name, input beat_t act, input beat_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int k, input beat_t v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic clr_exp(input int k);
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    function automatic int exp_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic pop_exp(input int k, output beat_t v);
        if (k == 0) v = exp_q0.pop_front();
        else        v = exp_q1.pop_front();
    endtask

    // Ready as the model expects it: the skid variant can take a beat unless
    // it already holds two; the plain variant only when empty or draining.
    function automatic logic pred_rdy(input int k);
        if (stall) return 1'b0;
        if (k == 0) return mrdy[0];
        return (mcnt[1] == 0) || out_ready;
    endfunction

    // Reference model, advanced on every active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0;
                mrdy[k] = 1'b1;
                held[k] = RSTV;
                clr_exp(k);
            end
        end else if (!stall) begin
            for (int k = 0; k < 2; k++) begin
                m_acc = in_valid && pred_rdy(k);
                m_deq = (mcnt[k] > 0) && out_ready;
                if (flush) begin
                    m_bub      = (held[k] & ~MASK) | (BUB & MASK);
                    held[k]    = m_bub;
                    mbuf[k][0] = m_bub;
                    mcnt[k]    = FV ? 1 : 0;
                    mrdy[k]    = 1'b1;
                    clr_exp(k);
                    if (FV) push_exp(k, m_bub);
                end else begin
                    if (m_deq) begin
                        mbuf[k][0] = mbuf[k][1];
                        mcnt[k]--;
                    end
                    if (m_acc) begin
                        mbuf[k][mcnt[k]] = in_data;
                        mcnt[k]++;
                        push_exp(k, in_data);
                    end
                    if (mcnt[k] > 0) held[k] = mbuf[k][0];
                    mrdy[k] = (mcnt[k] < 2);
                end
            end
        end
    end

    task automatic mon_one(input int k, input logic ov, input beat_t od,
                           input logic [1:0] cnt, input logic ird);
        beat_t e;
        chk($sformatf("k%0d.count", k), beat_t'(cnt), beat_t'(mcnt[k]));
        chk($sformatf("k%0d.out_valid", k), beat_t'(ov), beat_t'(mcnt[k] > 0));
        chk($sformatf("k%0d.in_ready", k), beat_t'(ird), beat_t'(pred_rdy(k)));
        chk($sformatf("k%0d.out_data_hold", k), od, held[k]);
        if (ov && out_ready && !stall) begin
            if (exp_size(k) == 0) begin
                checks++;
                errors++;
                $display("FAIL k%0d.unexpected_beat: got %h want none at %0t", k, od, $time);
            end else begin
                pop_exp(k, e);
                chk($sformatf("k%0d.beat", k), od, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_one(0, a_out_valid, a_out_data, a_count, a_in_ready);
            mon_one(1, b_out_valid, b_out_data, b_count, b_in_ready);
        end
    end

    task automatic drive(input logic v, input beat_t d, input logic ordy,
                         input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    localparam beat_t D0 = 64'h8000_0000_0050_0093;
    localparam beat_t D1 = 64'h8000_0004_0010_0113;
    localparam beat_t D2 = 64'h8000_0008_0030_0193;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("init.a_out_data", a_out_data, RSTV);
        chk("init.a_in_ready", beat_t'(a_in_ready), 64'd1);

        // Back-to-back stream with downstream always ready.
        drive(1'b1, D0, 1'b1, 1'b0, 1'b0); tick();
        chk("t2.data0", a_out_data, D0);
        chk("t2.count0", beat_t'(a_count), 64'd1);
        drive(1'b1, D1, 1'b1, 1'b0, 1'b0); tick();
        chk("t2.data1", a_out_data, D1);
        chk("t2.count1", beat_t'(a_count), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        chk("t2.drained", beat_t'(a_count), 64'd0);

        // Back-pressure: fill both entries, third beat must wait upstream.
        drive(1'b1, D0, 1'b0, 1'b0, 1'b0); tick();
        chk("t3.ready_after1", beat_t'(a_in_ready), 64'd1);
        drive(1'b1, D1, 1'b0, 1'b0, 1'b0); tick();
        chk("t3.count2", beat_t'(a_count), 64'd2);
        chk("t3.ready_after2", beat_t'(a_in_ready), 64'd0);
        drive(1'b1, D2, 1'b0, 1'b0, 1'b0); tick();
        chk("t3.hold_head", a_out_data, D0);
        drive(1'b1, D2, 1'b1, 1'b0, 1'b0); tick();
        chk("t3.second", a_out_data, D1);
        chk("t3.count_one", beat_t'(a_count), 64'd1);
        tick();
        chk("t3.third", a_out_data, D2);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        chk("t3.empty", beat_t'(a_count), 64'd0);

        // Flush keeps npc, replaces the instruction with NOP, drops the new beat.
        drive(1'b1, 64'h8000_0008_0020_8233, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 1'b1); tick();
        chk("t4.a_bubble", a_out_data, 64'h8000_0008_0000_0013);
        chk("t4.a_valid", beat_t'(a_out_valid), 64'd1);
        chk("t4.a_count", beat_t'(a_count), 64'd1);
        chk("t4.b_bubble", b_out_data, 64'h8000_0008_0000_0013);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        chk("t4.dropped", beat_t'(a_count), 64'd0);

        // Stall wins over flush, and the flush is not remembered.
        drive(1'b1, 64'h8000_000C_FFF0_0313, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h0000_0000_0000_1234, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t5.a_ready_stall", beat_t'(a_in_ready), 64'd0);
        chk("t5.b_ready_stall", beat_t'(b_in_ready), 64'd0);
        tick();
        chk("t5.a_held", a_out_data, 64'h8000_000C_FFF0_0313);
        chk("t5.a_count", beat_t'(a_count), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
        chk("t5.a_unflushed", a_out_data, 64'h8000_000C_FFF0_0313);
        chk("t5.b_unflushed", b_out_data, 64'h8000_000C_FFF0_0313);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();

        // Asynchronous reset in the middle of a cycle with both entries full.
        drive(1'b1, D0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, D1, 1'b0, 1'b0, 1'b0); tick();
        chk("t1.full", beat_t'(a_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t1.a_data", a_out_data, RSTV);
        chk("t1.a_valid", beat_t'(a_out_valid), 64'd0);
        chk("t1.a_count", beat_t'(a_count), 64'd0);
        chk("t1.b_data", b_out_data, RSTV);
        chk("t1.b_count", beat_t'(b_count), 64'd0);
        #2;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t1.a_ready", beat_t'(a_in_ready), 64'd1);
        tick();

        // Single-register mode with toggling back-pressure.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {$urandom, $urandom}, (i % 2) == 0, 1'b0, 1'b0);
            #1;
            chk("t6.b_count_le1", beat_t'(b_count <= 2'd1), 64'd1);
            tick();
        end

        // Randomised traffic with occasional stalls and flushes.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 24) == 0);
            tick();
        end

        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        chk("end.a_queue_empty", beat_t'(exp_q0.size()), 64'd0);
        chk("end.b_queue_empty", beat_t'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
